param_updown_counter: RTL and testbench

//  Parametrised, loadable up/down counter. It is the generalised successor of the

---
 rtl/updown_cnt_pkg.sv | 16 +
 rtl/cnt_next_logic.sv | 68 ++++++
 rtl/param_updown_counter.sv | 64 ++++++
 tb/tb_param_updown_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/updown_cnt_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Imported by cnt_next_logic and param_updown_counter.
package updown_cnt_pkg;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  // Fixed working width of clamp_load; callers cast in and out of it.
  localparam int unsigned CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] d,
                                                    input logic [CLAMP_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/cnt_next_logic.sv
// Combinational next-state logic for param_updown_counter: load clamp, up/down step,
// and wrap detection. Defining COUNT_SATURATE_EN selects saturating behaviour.
module cnt_next_logic
  import updown_cnt_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] c_out,
  input  logic             mode,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] c_out_d,
  output logic             wrap_d
);

  // One extra bit so "count+1 > MAX_VAL" cannot alias when MAX_VAL is all ones.
  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   max_ext;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] load_val;
  logic             past_max;
  logic             at_zero;

  assign c_ext    = {1'b0, c_out};
  assign max_ext  = {1'b0, MAX_VAL};
  assign inc_ext  = c_ext + {{WIDTH{1'b0}}, 1'b1};
  assign dec_val  = c_out - {{(WIDTH-1){1'b0}}, 1'b1};
  assign past_max = (inc_ext > max_ext);
  assign at_zero  = (c_out == '0);
  assign load_val = WIDTH'(clamp_load(CLAMP_W'(d_in), CLAMP_W'(MAX_VAL)));

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    c_out_d = c_out;
    wrap_d  = 1'b0;
    if (load) begin
      c_out_d = load_val;
    end else if (en) begin
      if (mode == MODE_UP) begin
        if (past_max) begin
`ifdef COUNT_SATURATE_EN
          c_out_d = MAX_VAL;
`else
          c_out_d = '0;
          wrap_d  = 1'b1;
`endif
        end else begin
          c_out_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
`ifdef COUNT_SATURATE_EN
          c_out_d = '0;
`else
          c_out_d = MAX_VAL;
          wrap_d  = 1'b1;
`endif
        end else begin
          c_out_d = dec_val;
        end
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with modulus, enable, terminal count and wrap pulse.
// Optional build macro COUNT_SATURATE_EN: saturate at the range ends instead of wrapping.
module param_updown_counter
  import updown_cnt_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] c_out,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > CLAMP_W) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 2..%0d", CLAMP_W);
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL must be >= 1");
  end
  if (RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("param_updown_counter: RST_VAL must be <= MAX_VAL");
  end

  logic [WIDTH-1:0] c_out_q;
  logic [WIDTH-1:0] c_out_d;
  logic             wrap_q;
  logic             wrap_d;

  cnt_next_logic #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .c_out   (c_out_q),
    .mode    (mode),
    .en      (en),
    .load    (load),
    .d_in    (d_in),
    .c_out_d (c_out_d),
    .wrap_d  (wrap_d)
  );

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_out_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      c_out_q <= c_out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign c_out = c_out_q;
  assign wrap  = wrap_q;
  assign tc    = (mode == MODE_UP) ? (c_out_q == MAX_VAL) : (c_out_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: a 4-bit mod-10 counter and an 8-bit full-range counter driven in
// parallel, compared each cycle against an arithmetic reference model.
module tb_param_updown_counter;

  localparam int MAX4 = 9;
  localparam int RST4 = 3;
  localparam int MAX8 = 255;
  localparam int RST8 = 0;

  logic       clk = 1'b0;
  logic       rst, en, load, mode;
  logic [7:0] d;
  logic [3:0] c_out4;
  logic       tc4, wrap4;
  logic [7:0] c_out8;
  logic       tc8, wrap8;

  int n_checks = 0;
  int n_fail   = 0;

  int m4_cnt, m8_cnt;
  bit m4_wrap, m8_wrap;
  bit m_valid = 1'b0;

  param_updown_counter #(
    .WIDTH   (4),
    .MAX_VAL (4'd9),
    .RST_VAL (4'd3)
  ) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .mode  (mode),
    .d_in  (d[3:0]),
    .c_out (c_out4),
    .tc    (tc4),
    .wrap  (wrap4)
  );

  param_updown_counter #(
    .WIDTH (8)
  ) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .mode  (mode),
    .d_in  (d),
    .c_out (c_out8),
    .tc    (tc8),
    .wrap  (wrap8)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour: the counter walks the range 0..max as plain integers.
  task automatic ref_step(input int cnt, input bit r, input bit l, input bit e, input bit m,
                          input int dv, input int max, input int rstv,
                          output int ncnt, output bit nwrap);
    bit sat;
`ifdef COUNT_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    ncnt  = cnt;
    nwrap = 1'b0;
    if (r) begin
      ncnt = rstv;
    end else if (l) begin
      ncnt = (dv > max) ? max : dv;
    end else if (e && m) begin
      if (cnt + 1 > max) begin
        ncnt  = sat ? max : 0;
        nwrap = !sat;
      end else begin
        ncnt = cnt + 1;
      end
    end else if (e) begin
      if (cnt - 1 < 0) begin
        ncnt  = sat ? 0 : max;
        nwrap = !sat;
      end else begin
        ncnt = cnt - 1;
      end
    end
  endtask

  function automatic bit ref_tc(input int cnt, input bit m, input int max);
    return m ? (cnt == max) : (cnt == 0);
  endfunction

  // Drive on negedge, check tc combinationally, then check registered state after posedge.
  task automatic cyc(input bit r, input bit l, input bit e, input bit m, input logic [7:0] dv);
    @(negedge clk);
    rst  = r;
    load = l;
    en   = e;
    mode = m;
    d    = dv;
    #1;
    if (m_valid) begin
      check("tc4", 32'(tc4), 32'(ref_tc(m4_cnt, m, MAX4)));
      check("tc8", 32'(tc8), 32'(ref_tc(m8_cnt, m, MAX8)));
    end
    @(posedge clk);
    ref_step(m4_cnt, r, l, e, m, int'(dv[3:0]), MAX4, RST4, m4_cnt, m4_wrap);
    ref_step(m8_cnt, r, l, e, m, int'(dv), MAX8, RST8, m8_cnt, m8_wrap);
    #1;
    if (r || m_valid) begin
      m_valid = 1'b1;
      check("c_out4", 32'(c_out4), 32'(m4_cnt));
      check("wrap4", 32'(wrap4), 32'(m4_wrap));
      check("c_out8", 32'(c_out8), 32'(m8_cnt));
      check("wrap8", 32'(wrap8), 32'(m8_wrap));
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    mode = 1'b1;
    d    = '0;
    m4_cnt  = 0;
    m8_cnt  = 0;
    m4_wrap = 1'b0;
    m8_wrap = 1'b0;

    // Reset, then hold with en low.
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'h00);

    // Up through MAX_VAL.
    cyc(0, 1, 1, 1, 8'h07);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h00);

    // Down through zero.
    cyc(0, 1, 0, 0, 8'h01);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'h00);

    // Load beats enable; out-of-range load clamps.
    cyc(0, 1, 1, 1, 8'h0C);
    cyc(0, 1, 0, 1, 8'h02);

    // Reset beats load mid-count; direction flip with no dead cycle.
    cyc(0, 0, 1, 1, 8'h00);
    cyc(1, 1, 1, 1, 8'h05);
    cyc(0, 1, 0, 1, 8'h04);
    cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);

    // Range ends of both counters (8-bit: full range, 4-bit: clamped load).
    cyc(0, 1, 0, 1, 8'hFE);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 1, 0, 1, 8'h08);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 1, 0, 0, 8'h01);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'h00);

    // Randomised run; loads biased toward the top of the 8-bit range to reach its wrap.
    for (int i = 0; i < 600; i++) begin
      bit         r, l, e, m;
      logic [7:0] dv;
      r  = ($urandom_range(0, 40) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = (i % 64 < 32) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      dv = 8'($urandom);
      if ($urandom_range(0, 1) == 1) dv = dv | 8'hF8;
      cyc(r, l, e, m, dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
